// File: rtl/uart_flow_checker.sv
// uart_flow_checker: per-channel RTS/receive-done handshake monitor.
// Each channel has its own FSM and latency counter. Violations set sticky
// flags, bump a saturating counter and record the first failing channel
// and error kind.
// Optional feature macro: UART_FC_SPURIOUS_CHK_EN. When it is defined,
// rts_n low while idle with rx_done low is flagged as error code 3.
module uart_flow_checker #(
    parameter int unsigned NUM_CH  = 1,
    parameter int unsigned MAX_LAT = 0,
    parameter int unsigned CNT_W   = 8,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clr,
    input  logic [NUM_CH-1:0] rx_done,
    input  logic [NUM_CH-1:0] rts_n,
    output logic [NUM_CH-1:0] err_flag,
    output logic              err_any,
    output logic [CNT_W-1:0]  err_count,
    output logic              first_vld,
    output logic [CH_W-1:0]   first_ch,
    output logic [1:0]        first_code
);

    localparam int unsigned LAT_W = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
    localparam int unsigned SUM_W = CNT_W + 5;
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);

    localparam logic [1:0] CODE_ASSERT  = 2'd1;
    localparam logic [1:0] CODE_RELEASE = 2'd2;
    localparam logic [1:0] CODE_GLITCH  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ASSERT,
        HELD,
        WAIT_RELEASE,
        RESYNC
    } state_t;

    state_t           state_q [NUM_CH];
    state_t           state_d [NUM_CH];
    logic [LAT_W-1:0] cnt_q   [NUM_CH];
    logic [LAT_W-1:0] cnt_d   [NUM_CH];
    logic [1:0]       ch_code [NUM_CH];
    logic [NUM_CH-1:0] ch_err;

    logic [NUM_CH-1:0] flag_nxt;
    logic [CNT_W-1:0]  cnt_base;
    logic [SUM_W-1:0]  cnt_sum;
    logic [CNT_W-1:0]  count_nxt;
    logic [4:0]        n_err;
    logic              vld_nxt;
    logic [CH_W-1:0]   ch_nxt;
    logic [1:0]        code_nxt;
    logic [CH_W-1:0]   low_ch;
    logic [1:0]        low_code;

    // Per-channel FSM state and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= IDLE;
                cnt_q[ch]   <= '0;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
        end
    end

    // Per-channel next state, latency count and error detection.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            ch_err[ch]  = 1'b0;
            ch_code[ch] = 2'd0;
            if (enable) begin
                case (state_q[ch])
                    IDLE: begin
                        if (rx_done[ch]) begin
                            if (!rts_n[ch]) begin
                                state_d[ch] = HELD;
                            end else if (MAX_LAT == 0) begin
                                ch_err[ch]  = 1'b1;
                                ch_code[ch] = CODE_ASSERT;
                            end else begin
                                state_d[ch] = WAIT_ASSERT;
                                cnt_d[ch]   = LAT_W'(1);
                            end
                        end
`ifdef UART_FC_SPURIOUS_CHK_EN
                        else if (!rts_n[ch]) begin
                            ch_err[ch]  = 1'b1;
                            ch_code[ch] = CODE_GLITCH;
                        end
`endif
                    end
                    WAIT_ASSERT: begin
                        if (!rts_n[ch]) begin
                            state_d[ch] = HELD;
                            cnt_d[ch]   = '0;
                        end else if (!rx_done[ch]) begin
                            state_d[ch] = IDLE;
                            cnt_d[ch]   = '0;
                        end else if (cnt_q[ch] == LAT_MAX) begin
                            ch_err[ch]  = 1'b1;
                            ch_code[ch] = CODE_ASSERT;
                        end else begin
                            cnt_d[ch] = cnt_q[ch] + LAT_W'(1);
                        end
                    end
                    HELD: begin
                        if (!rx_done[ch] && rts_n[ch]) begin
                            state_d[ch] = IDLE;
                        end else if (!rx_done[ch]) begin
                            if (MAX_LAT == 0) begin
                                ch_err[ch]  = 1'b1;
                                ch_code[ch] = CODE_RELEASE;
                            end else begin
                                state_d[ch] = WAIT_RELEASE;
                                cnt_d[ch]   = LAT_W'(1);
                            end
                        end else if (rts_n[ch]) begin
                            ch_err[ch]  = 1'b1;
                            ch_code[ch] = CODE_GLITCH;
                        end
                    end
                    WAIT_RELEASE: begin
                        if (rts_n[ch]) begin
                            state_d[ch] = IDLE;
                            cnt_d[ch]   = '0;
                        end else if (rx_done[ch]) begin
                            state_d[ch] = HELD;
                            cnt_d[ch]   = '0;
                        end else if (cnt_q[ch] == LAT_MAX) begin
                            ch_err[ch]  = 1'b1;
                            ch_code[ch] = CODE_RELEASE;
                        end else begin
                            cnt_d[ch] = cnt_q[ch] + LAT_W'(1);
                        end
                    end
                    RESYNC: begin
                        if (rx_done[ch] && !rts_n[ch]) begin
                            state_d[ch] = HELD;
                        end else if (!rx_done[ch] && rts_n[ch]) begin
                            state_d[ch] = IDLE;
                        end
                    end
                    default: begin
                        state_d[ch] = IDLE;
                        cnt_d[ch]   = '0;
                    end
                endcase
                // One error per episode: park in RESYNC until inputs agree.
                if (ch_err[ch]) begin
                    state_d[ch] = RESYNC;
                    cnt_d[ch]   = '0;
                end
            end else begin
                state_d[ch] = IDLE;
                cnt_d[ch]   = '0;
            end
        end
    end

    // Error aggregation: popcount, lowest erring channel, clear-then-apply.
    always_comb begin
        n_err    = 5'd0;
        low_ch   = '0;
        low_code = 2'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            n_err = n_err + 5'(ch_err[i]);
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_err[i]) begin
                low_ch   = CH_W'(i);
                low_code = ch_code[i];
            end
        end
        flag_nxt  = (clr ? '0 : err_flag) | ch_err;
        cnt_base  = clr ? '0 : err_count;
        cnt_sum   = SUM_W'(cnt_base) + SUM_W'(n_err);
        count_nxt = (|cnt_sum[SUM_W-1:CNT_W]) ? '1 : cnt_sum[CNT_W-1:0];
        vld_nxt   = clr ? 1'b0 : first_vld;
        ch_nxt    = clr ? '0 : first_ch;
        code_nxt  = clr ? 2'd0 : first_code;
        if (!vld_nxt && (|ch_err)) begin
            vld_nxt  = 1'b1;
            ch_nxt   = low_ch;
            code_nxt = low_code;
        end
    end

    // Registered error outputs; err_any follows err_flag by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag   <= '0;
            err_any    <= 1'b0;
            err_count  <= '0;
            first_vld  <= 1'b0;
            first_ch   <= '0;
            first_code <= 2'd0;
        end else begin
            err_flag   <= flag_nxt;
            err_any    <= |err_flag;
            err_count  <= count_nxt;
            first_vld  <= vld_nxt;
            first_ch   <= ch_nxt;
            first_code <= code_nxt;
        end
    end

endmodule

// File: tb/tb_uart_flow_checker.sv
// Testbench for uart_flow_checker: table-driven single-channel run plus
// hand-written multi-channel, zero-latency, spurious and reset sequences.
module tb_uart_flow_checker;

    logic clk;
    logic rst_n;

    // dut_a: 1 channel, MAX_LAT=3, CNT_W=2
    logic       a_en, a_clr;
    logic [0:0] a_rx, a_rts, a_flag, a_ch;
    logic       a_any, a_vld;
    logic [1:0] a_cnt, a_code;

    // dut_b: 4 channels, MAX_LAT=2, CNT_W=8
    logic       b_en, b_clr;
    logic [3:0] b_rx, b_rts, b_flag;
    logic       b_any, b_vld;
    logic [7:0] b_cnt;
    logic [1:0] b_ch, b_code;

    // dut_c: 1 channel, MAX_LAT=0, CNT_W=8
    logic       c_en, c_clr;
    logic [0:0] c_rx, c_rts, c_flag, c_ch;
    logic       c_any, c_vld;
    logic [7:0] c_cnt;
    logic [1:0] c_code;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef UART_FC_SPURIOUS_CHK_EN
    localparam bit SPUR = 1'b1;
`else
    localparam bit SPUR = 1'b0;
`endif

    uart_flow_checker #(.NUM_CH(1), .MAX_LAT(3), .CNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(a_en), .clr(a_clr),
        .rx_done(a_rx), .rts_n(a_rts), .err_flag(a_flag), .err_any(a_any),
        .err_count(a_cnt), .first_vld(a_vld), .first_ch(a_ch), .first_code(a_code)
    );

    uart_flow_checker #(.NUM_CH(4), .MAX_LAT(2), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(b_en), .clr(b_clr),
        .rx_done(b_rx), .rts_n(b_rts), .err_flag(b_flag), .err_any(b_any),
        .err_count(b_cnt), .first_vld(b_vld), .first_ch(b_ch), .first_code(b_code)
    );

    uart_flow_checker #(.NUM_CH(1), .MAX_LAT(0), .CNT_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .enable(c_en), .clr(c_clr),
        .rx_done(c_rx), .rts_n(c_rts), .err_flag(c_flag), .err_any(c_any),
        .err_count(c_cnt), .first_vld(c_vld), .first_ch(c_ch), .first_code(c_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       clr;
        logic       rx;
        logic       rts;
        logic       e_flag;
        logic [1:0] e_cnt;
        logic       e_vld;
        logic [1:0] e_code;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic clr, input logic rx, input logic rts,
                       input logic f, input logic [1:0] c, input logic v, input logic [1:0] code);
        vec_t t;
        t.en = en; t.clr = clr; t.rx = rx; t.rts = rts;
        t.e_flag = f; t.e_cnt = c; t.e_vld = v; t.e_code = code;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic prev_flag;

        rst_n = 1'b0;
        a_en = 1'b1; a_clr = 1'b0; a_rx = 1'b0; a_rts = 1'b1;
        b_en = 1'b1; b_clr = 1'b0; b_rx = 4'h0; b_rts = 4'hF;
        c_en = 1'b1; c_clr = 1'b0; c_rx = 1'b0; c_rts = 1'b1;

        // en clr rx rts | flag cnt vld code
        add(1,0,0,1, 0,0,0,0);
        add(1,0,1,1, 0,0,0,0);  // rx_done rises, rts late
        add(1,0,1,1, 0,0,0,0);
        add(1,0,1,1, 0,0,0,0);
        add(1,0,1,0, 0,0,0,0);  // rts at k+3: in window
        add(1,0,0,0, 0,0,0,0);
        add(1,0,0,1, 0,0,0,0);
        add(1,0,1,1, 0,0,0,0);
        add(1,0,1,1, 0,0,0,0);
        add(1,0,1,1, 0,0,0,0);
        add(1,0,1,1, 1,1,1,1);  // still high at k+3: assert timeout
        add(1,0,1,0, 1,1,1,1);
        add(1,0,0,1, 1,1,1,1);
        add(1,0,1,0, 1,1,1,1);
        add(1,0,1,1, 1,2,1,1);  // early release, first_code kept
        add(1,0,1,1, 1,2,1,1);  // resync: no repeat
        add(1,0,0,1, 1,2,1,1);
        add(1,0,1,0, 1,2,1,1);
        add(1,0,1,1, 1,3,1,1);
        add(1,0,0,1, 1,3,1,1);
        add(1,0,1,0, 1,3,1,1);
        add(1,0,1,1, 1,3,1,1);  // 4th: saturated
        add(1,0,0,1, 1,3,1,1);
        add(1,0,1,0, 1,3,1,1);
        add(1,0,1,1, 1,3,1,1);  // 5th
        add(1,0,0,1, 1,3,1,1);
        add(1,0,1,0, 1,3,1,1);
        add(1,1,1,1, 1,1,1,3);  // clr with new violation: error wins
        add(1,1,0,1, 0,0,0,0);  // plain clear
        add(1,0,1,1, 0,0,0,0);
        add(1,0,1,1, 0,0,0,0);
        add(0,0,1,1, 0,0,0,0);  // disabled inside the window
        add(0,0,1,1, 0,0,0,0);
        add(1,0,1,1, 0,0,0,0);
        add(1,0,0,1, 0,0,0,0);  // rx_done drops before timeout
        add(1,0,1,0, 0,0,0,0);
        add(1,0,1,1, 1,1,1,3);
        add(0,0,0,1, 1,1,1,3);  // disabled: outputs hold
        add(0,0,1,1, 1,1,1,3);
        add(1,0,0,1, 1,1,1,3);

        // Reset state
        #12;
        chk("rst_a_flag", a_flag, 0);
        chk("rst_a_cnt", a_cnt, 0);
        chk("rst_a_vld", a_vld, 0);
        chk("rst_b_flag", b_flag, 0);
        chk("rst_b_any", b_any, 0);
        chk("rst_b_ch", b_ch, 0);
        chk("rst_c_code", c_code, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table run on dut_a
        prev_flag = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            a_en = vecs[i].en; a_clr = vecs[i].clr;
            a_rx = vecs[i].rx; a_rts = vecs[i].rts;
            step();
            chk($sformatf("a_flag[%0d]", i), a_flag, vecs[i].e_flag);
            chk($sformatf("a_cnt[%0d]", i), a_cnt, vecs[i].e_cnt);
            chk($sformatf("a_vld[%0d]", i), a_vld, vecs[i].e_vld);
            chk($sformatf("a_code[%0d]", i), a_code, vecs[i].e_code);
            chk($sformatf("a_any[%0d]", i), a_any, prev_flag);
            prev_flag = vecs[i].e_flag;
        end
        a_en = 1'b1; a_clr = 1'b0; a_rx = 1'b0; a_rts = 1'b1;

        // dut_c, MAX_LAT=0: simultaneous handshake is clean
        c_rx = 1'b1; c_rts = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("c_held_flag", c_flag, 0);
        end
        c_rx = 1'b0; c_rts = 1'b1;
        step();
        chk("c_rel_flag", c_flag, 0);
        chk("c_rel_cnt", c_cnt, 0);
        c_rx = 1'b1; c_rts = 1'b1;
        step();
        chk("c_asrt_flag", c_flag, 1);
        chk("c_asrt_cnt", c_cnt, 1);
        chk("c_asrt_code", c_code, 1);
        c_rx = 1'b1; c_rts = 1'b0;
        step();
        c_rx = 1'b0; c_rts = 1'b0;
        step();
        chk("c_rel_to_cnt", c_cnt, 2);
        chk("c_rel_to_code", c_code, 1);
        c_rx = 1'b0; c_rts = 1'b1;
        step();

        // dut_b: channels 1 and 2 time out on release together
        b_rx = 4'b0110; b_rts = 4'b1001;
        step();
        b_rx = 4'b0000;
        step();  // sample k
        chk("b_k_flag", b_flag, 0);
        step();  // k+1
        chk("b_k1_flag", b_flag, 0);
        step();  // k+2: timeout
        chk("b_to_flag", b_flag, 4'b0110);
        chk("b_to_cnt", b_cnt, 2);
        chk("b_to_ch", b_ch, 1);
        chk("b_to_code", b_code, 2);
        chk("b_to_any", b_any, 0);
        b_rts = 4'b1111;
        step();
        chk("b_any_lag", b_any, 1);
        // channel 3 assert timeout later: first_* unchanged
        b_rx = 4'b1000;
        step();
        step();
        chk("b_ch3_pre", b_cnt, 2);
        step();
        chk("b_ch3_flag", b_flag, 4'b1110);
        chk("b_ch3_cnt", b_cnt, 3);
        chk("b_ch3_first", b_ch, 1);
        b_rx = 4'b0000;
        step();

        // Spurious rts_n in IDLE (dut_a idle, flag=1 cnt=1 code=3)
        a_rx = 1'b0; a_rts = 1'b0;
        step();
        chk("a_spur_cnt", a_cnt, SPUR ? 2 : 1);
        chk("a_spur_code", a_code, 3);
        a_rts = 1'b1;
        step();

        // Async reset mid-episode
        a_rx = 1'b1; a_rts = 1'b1;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_flag", a_flag, 0);
        chk("arst_cnt", a_cnt, 0);
        chk("arst_vld", a_vld, 0);
        chk("arst_any", a_any, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_wait", a_flag, 0);
        end
        a_rts = 1'b0;
        step();
        chk("post_rst_flag", a_flag, 0);
        chk("post_rst_cnt", a_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
